memory_port_arbiter: RTL and testbench
======================================

// Module: memory_port_arbiter
// PURPOSE
//  Shares one memory port (local SRAM or WB master side of the memory controller) between two requesters, A and B.
//  Round-robin arbitration with a registered grant. A granted transaction is held until the memory completes it.
//  Sits between two core/DMA-side ports and the memory controller's local memory or WB interface.
// PARAMETERS
//  ADDRESS_WIDTH   24   width of requester and memory address buses
//  TIMEOUT_CYCLES  255  granted cycles before forced abort (only with MEMORY_ARBITER_TIMEOUT_EN); 1..65535
// PORTS
//  clk                   in   1   clock, rising edge
//  rst                   in   1   asynchronous reset, active-high
//  reqA/BAddress         in   AW  requester address
//  reqA/BByteSelect      in   4   byte lanes
//  reqA/BEnable          in   1   request; held high until reqX busy seen low
//  reqA/BWriteEnable     in   1   1 = write
//  reqA/BDataWrite       in   32  write data
//  reqA/BDataRead        out  32  read data; valid on the completion cycle
//  reqA/BBusy            out  1   stall
//  memAddress            out  AW  shared port address
//  memByteSelect         out  4   byte lanes
//  memEnable             out  1   shared port request
//  memWriteEnable        out  1   write
//  memDataWrite          out  32  write data
//  memDataRead           in   32  read data
//  memBusy               in   1   memory stall; low with memEnable high = completion
//  arbError              out  1   one-cycle pulse on timeout abort (only with the macro)
// BEHAVIOUR
//  Async reset: state=IDLE, lastGrant=B (so A wins first), all mem* outputs 0, reqX busy 0, reqX dataRead all-ones.
//  States: IDLE, GRANT_A, GRANT_B (registered). mem* outputs are combinational from the state:
//    GRANT_X forwards requester X's fields. memEnable = reqXEnable. IDLE drives all zeros.
//  IDLE: if only one requester is enabled, go to its GRANT state.
//    If both are enabled, grant the one that is not lastGrant. Otherwise stay in IDLE.
//  Grant latency: request seen in IDLE at cycle N -> memEnable high at cycle N+1. Earliest completion is N+1.
//  Completion: in GRANT_X, cycle where reqXEnable=1 and memBusy=0.
//    That cycle: reqXBusy=0 and reqXDataRead=memDataRead. lastGrant<=X.
//    Next state: GRANT_other if the other requester is enabled (back-to-back, no IDLE bubble), else IDLE.
//  reqXBusy = reqXEnable && !(state==GRANT_X && !memBusy). A non-requesting port has busy=0.
//  reqXDataRead = memDataRead while in GRANT_X, else all-ones.
//  Requester drops enable while granted: abort. Next state=IDLE (or grant the other if it is enabled).
//    lastGrant is not updated. The memory sees memEnable fall the same cycle.
//  A completing requester that re-asserts immediately loses to a waiting peer. No starvation: max wait is one transaction.
//  Requester fields must be stable while enable=1. The arbiter does not register them.
//  Reset asserted mid-transaction: immediate return to reset values. The in-flight access is dropped.
// CONFIGURATION
//  MEMORY_ARBITER_TIMEOUT_EN defined:
//    A 16-bit counter clears on entry to a GRANT state and increments each granted cycle without completion.
//    At count==TIMEOUT_CYCLES: requester busy=0, dataRead=all-ones, arbError pulses 1 cycle.
//    Then arbitrate as on completion; lastGrant is updated.
//  Not defined: no counter, arbError tied 0, grants are held indefinitely.
// STRUCTURE
//  Shared package/include memory_arbiter_defs: state encodings (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2).
//    Also the read-default constant 32'hFFFF_FFFF and the grant-id constants.
//  One sub-module: memory_arbiter_timeout (counter + compare, instantiated only under the macro).
//  Round-robin select and muxing stay in the top module.
// TESTING
//  1 A only, read 0x000010, memBusy low -> memEnable at cycle+1. A busy low that cycle. dataRead=memDataRead (0xDEADBEEF).
//  2 A and B both enabled from reset -> A granted first. After A completes, B is granted next cycle (no IDLE). lastGrant=B.
//  3 B writes 0x12345678 with byteSelect 4'b0011, memBusy high 3 cycles -> memWriteEnable/memDataWrite stable 4 cycles.
//    B busy high 3 cycles, then low.
//  4 A completes and re-asserts while B waits -> B granted before A's second access.
//  5 A drops enable mid-grant -> memEnable low the same cycle, state IDLE next cycle, lastGrant unchanged.
//  6 (macro) memBusy stuck high, TIMEOUT_CYCLES=4 -> after 4 granted cycles: A busy=0, dataRead=0xFFFFFFFF.
//    arbError is a single pulse, then B is granted.

Source files
------------

// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// state encodings, grant ids and the idle read-data value.
package memory_arbiter_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arbState_t;

  localparam logic        GRANT_ID_A   = 1'b0;
  localparam logic        GRANT_ID_B   = 1'b1;
  localparam logic [31:0] READ_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/memory_arbiter_timeout.sv
// Grant watchdog: counts granted cycles without completion and flags
// when the count reaches TIMEOUT_CYCLES. Only used with MEMORY_ARBITER_TIMEOUT_EN.
module memory_arbiter_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,    // entering a grant state this cycle
  input  logic advance,  // granted and not completing this cycle
  output logic expired
);

  logic [15:0] count;

  // Cleared on every new grant, advanced on each stalled granted cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (start)   count <= '0;
    else if (advance) count <= count + 16'd1;
  end

  assign expired = (count == 16'(TIMEOUT_CYCLES));

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory port between requesters A and B.
// Grant is registered; mem* outputs are muxed combinationally from it.
// Optional grant timeout enabled by defining MEMORY_ARBITER_TIMEOUT_EN.
module memory_port_arbiter
  import memory_arbiter_defs::*;
#(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] reqAAddress,
  input  logic [3:0]               reqAByteSelect,
  input  logic                     reqAEnable,
  input  logic                     reqAWriteEnable,
  input  logic [31:0]              reqADataWrite,
  output logic [31:0]              reqADataRead,
  output logic                     reqABusy,
  input  logic [ADDRESS_WIDTH-1:0] reqBAddress,
  input  logic [3:0]               reqBByteSelect,
  input  logic                     reqBEnable,
  input  logic                     reqBWriteEnable,
  input  logic [31:0]              reqBDataWrite,
  output logic [31:0]              reqBDataRead,
  output logic                     reqBBusy,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  output logic [3:0]               memByteSelect,
  output logic                     memEnable,
  output logic                     memWriteEnable,
  output logic [31:0]              memDataWrite,
  input  logic [31:0]              memDataRead,
  input  logic                     memBusy,
  output logic                     arbError
);

  arbState_t state, stateNext;
  logic      lastGrant, lastGrantNext;
  logic      grantA, grantB, doneA, doneB;
  logic      expired, timeoutA, timeoutB;

  assign grantA = (state == GRANT_A);
  assign grantB = (state == GRANT_B);
  assign doneA  = grantA && reqAEnable && !memBusy;
  assign doneB  = grantB && reqBEnable && !memBusy;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic timerStart;
  assign timerStart = (stateNext != IDLE) && (stateNext != state);

  memory_arbiter_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (timerStart),
    .advance ((grantA || grantB) && !(doneA || doneB)),
    .expired (expired)
  );
  assign arbError = timeoutA || timeoutB;
`else
  assign expired  = 1'b0;
  assign arbError = 1'b0;
`endif

  // A timeout only counts while the requester is still asking and memory stalls
  assign timeoutA = grantA && reqAEnable && memBusy && expired;
  assign timeoutB = grantB && reqBEnable && memBusy && expired;

  // Grant and round-robin history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= GRANT_ID_B;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
    end
  end

  // Arbitration: a finishing or aborting grant hands straight to a waiting peer
  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    case (state)
      IDLE: begin
        if (reqAEnable && reqBEnable)
          stateNext = (lastGrant == GRANT_ID_A) ? GRANT_B : GRANT_A;
        else if (reqAEnable) stateNext = GRANT_A;
        else if (reqBEnable) stateNext = GRANT_B;
      end
      GRANT_A: begin
        if (!reqAEnable) begin
          stateNext = reqBEnable ? GRANT_B : IDLE;  // abort, history untouched
        end else if (doneA || timeoutA) begin
          lastGrantNext = GRANT_ID_A;
          stateNext     = reqBEnable ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (!reqBEnable) begin
          stateNext = reqAEnable ? GRANT_A : IDLE;
        end else if (doneB || timeoutB) begin
          lastGrantNext = GRANT_ID_B;
          stateNext     = reqAEnable ? GRANT_A : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Shared-port mux and requester status; IDLE drives the port to zero
  always_comb begin
    memAddress     = '0;
    memByteSelect  = '0;
    memEnable      = 1'b0;
    memWriteEnable = 1'b0;
    memDataWrite   = '0;
    if (grantA) begin
      memAddress     = reqAAddress;
      memByteSelect  = reqAByteSelect;
      memEnable      = reqAEnable;
      memWriteEnable = reqAWriteEnable;
      memDataWrite   = reqADataWrite;
    end else if (grantB) begin
      memAddress     = reqBAddress;
      memByteSelect  = reqBByteSelect;
      memEnable      = reqBEnable;
      memWriteEnable = reqBWriteEnable;
      memDataWrite   = reqBDataWrite;
    end
    reqABusy     = reqAEnable && !doneA && !timeoutA;
    reqBBusy     = reqBEnable && !doneB && !timeoutB;
    reqADataRead = (grantA && !timeoutA) ? memDataRead : READ_DEFAULT;
    reqBDataRead = (grantB && !timeoutB) ? memDataRead : READ_DEFAULT;
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: stimulus pushes expected
// completions, a negedge monitor pops and compares each memory completion.
module tb_memory_port_arbiter;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  typedef struct {
    logic        port;  // 0 = A, 1 = B
    logic [23:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  bs;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [23:0] reqAAddress, reqBAddress, memAddress;
  logic [3:0]  reqAByteSelect, reqBByteSelect, memByteSelect;
  logic        reqAEnable, reqBEnable, reqAWriteEnable, reqBWriteEnable;
  logic [31:0] reqADataWrite, reqBDataWrite, reqADataRead, reqBDataRead;
  logic        reqABusy, reqBBusy, memEnable, memWriteEnable, memBusy, arbError;
  logic [31:0] memDataWrite, memDataRead;

  exp_t q[$];
  int   checks = 0, failures = 0;

  memory_port_arbiter #(.ADDRESS_WIDTH(24), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .reqAAddress(reqAAddress), .reqAByteSelect(reqAByteSelect), .reqAEnable(reqAEnable),
    .reqAWriteEnable(reqAWriteEnable), .reqADataWrite(reqADataWrite),
    .reqADataRead(reqADataRead), .reqABusy(reqABusy),
    .reqBAddress(reqBAddress), .reqBByteSelect(reqBByteSelect), .reqBEnable(reqBEnable),
    .reqBWriteEnable(reqBWriteEnable), .reqBDataWrite(reqBDataWrite),
    .reqBDataRead(reqBDataRead), .reqBBusy(reqBBusy),
    .memAddress(memAddress), .memByteSelect(memByteSelect), .memEnable(memEnable),
    .memWriteEnable(memWriteEnable), .memDataWrite(memDataWrite),
    .memDataRead(memDataRead), .memBusy(memBusy), .arbError(arbError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    reqAAddress = '0; reqAByteSelect = 4'hF; reqAEnable = 0; reqAWriteEnable = 0; reqADataWrite = '0;
    reqBAddress = '0; reqBByteSelect = 4'hF; reqBEnable = 0; reqBWriteEnable = 0; reqBDataWrite = '0;
    memBusy = 0; memDataRead = '0;
    @(negedge clk);
    chk("rst_memEn", memEnable, 0);
    chk("rst_memAddr", memAddress, 0);
    chk("rst_busyA", reqABusy, 0);
    chk("rst_readA", reqADataRead, 32'hFFFF_FFFF);
    chk("rst_readB", reqBDataRead, 32'hFFFF_FFFF);
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every memory completion must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic p;
    if (!rst && memEnable && !memBusy) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected actual_addr=%h required=none", memAddress);
      end else begin
        e = q.pop_front();
        p = !(reqAEnable && !reqABusy);
        chk("sb_port", {31'd0, p}, {31'd0, e.port});
        chk("sb_addr", {8'd0, memAddress}, {8'd0, e.addr});
        chk("sb_we", {31'd0, memWriteEnable}, {31'd0, e.we});
        chk("sb_wdata", memDataWrite, e.wd);
        chk("sb_bsel", {28'd0, memByteSelect}, {28'd0, e.bs});
        chk("sb_rdata", p ? reqBDataRead : reqADataRead, e.rd);
      end
    end
  end

  initial begin
    // 1: A alone, read, single-cycle completion
    reset_dut();
    reqAAddress = 24'h10; memDataRead = 32'hDEAD_BEEF; reqAEnable = 1;
    q.push_back('{1'b0, 24'h10, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF});
    @(negedge clk); chk("t1_idle_memEn", memEnable, 0); chk("t1_idle_busyA", reqABusy, 1);
    tick();
    @(negedge clk); chk("t1_memEn", memEnable, 1); chk("t1_busyA", reqABusy, 0);
    chk("t1_readA", reqADataRead, 32'hDEAD_BEEF);
    tick(); reqAEnable = 0;
    @(negedge clk); chk("t1_after_memEn", memEnable, 0);

    // 2: both from reset, A first, B back-to-back
    reset_dut();
    reqAAddress = 24'h100; reqBAddress = 24'h200; memDataRead = 32'h1111_1111;
    reqAEnable = 1; reqBEnable = 1;
    q.push_back('{1'b0, 24'h100, 1'b0, 32'h0, 4'hF, 32'h1111_1111});
    q.push_back('{1'b1, 24'h200, 1'b0, 32'h0, 4'hF, 32'h2222_2222});
    @(negedge clk); chk("t2_idle_memEn", memEnable, 0);
    tick();
    @(negedge clk); chk("t2_first_addr", memAddress, 24'h100); chk("t2_busyB", reqBBusy, 1);
    tick(); reqAEnable = 0; memDataRead = 32'h2222_2222;
    @(negedge clk); chk("t2_b2b_memEn", memEnable, 1); chk("t2_b2b_addr", memAddress, 24'h200);
    tick(); reqBEnable = 0;
    @(negedge clk); chk("t2_end_memEn", memEnable, 0);

    // 3: B write stalled 3 cycles
    reqBAddress = 24'h300; reqBWriteEnable = 1; reqBDataWrite = 32'h1234_5678;
    reqBByteSelect = 4'b0011; memBusy = 1; memDataRead = 32'hCAFE_0000; reqBEnable = 1;
    q.push_back('{1'b1, 24'h300, 1'b1, 32'h1234_5678, 4'b0011, 32'hCAFE_0000});
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memBusy = 0;
      @(negedge clk);
      chk("t3_we", memWriteEnable, 1);
      chk("t3_wdata", memDataWrite, 32'h1234_5678);
      chk("t3_bsel", memByteSelect, 4'b0011);
      chk("t3_busyB", reqBBusy, (i < 3) ? 1 : 0);
      tick();
    end
    reqBEnable = 0; reqBWriteEnable = 0; reqBByteSelect = 4'hF; reqBDataWrite = '0;

    // 4: A completes and re-asserts while B waits -> B goes first
    reqAAddress = 24'h400; reqBAddress = 24'h500; memDataRead = 32'h4444_0000;
    reqAEnable = 1; reqBEnable = 1;
    q.push_back('{1'b0, 24'h400, 1'b0, 32'h0, 4'hF, 32'h4444_0000});
    q.push_back('{1'b1, 24'h500, 1'b0, 32'h0, 4'hF, 32'h5555_0000});
    q.push_back('{1'b0, 24'h410, 1'b0, 32'h0, 4'hF, 32'h4444_1111});
    tick();
    @(negedge clk); chk("t4_a_addr", memAddress, 24'h400);
    tick(); reqAAddress = 24'h410; memDataRead = 32'h5555_0000;
    @(negedge clk); chk("t4_b_addr", memAddress, 24'h500); chk("t4_a_waits", reqABusy, 1);
    tick(); reqBEnable = 0; memDataRead = 32'h4444_1111;
    @(negedge clk); chk("t4_a2_addr", memAddress, 24'h410);
    tick(); reqAEnable = 0;

    // 5: B solo so history points at B, then A aborts mid-grant
    reqBAddress = 24'h600; memDataRead = 32'h6666_0000; reqBEnable = 1;
    q.push_back('{1'b1, 24'h600, 1'b0, 32'h0, 4'hF, 32'h6666_0000});
    tick();
    @(negedge clk); chk("t5_b_addr", memAddress, 24'h600);
    tick(); reqBEnable = 0;
    reqAAddress = 24'h700; memBusy = 1; reqAEnable = 1;
    tick();
    @(negedge clk); chk("t5_granted_memEn", memEnable, 1);
    tick(); reqAEnable = 0;
    @(negedge clk); chk("t5_abort_memEn", memEnable, 0); chk("t5_abort_busyA", reqABusy, 0);
    tick();
    reqAAddress = 24'h710; reqBAddress = 24'h720; memBusy = 0; memDataRead = 32'h7777_0000;
    reqAEnable = 1; reqBEnable = 1;
    q.push_back('{1'b0, 24'h710, 1'b0, 32'h0, 4'hF, 32'h7777_0000});
    q.push_back('{1'b1, 24'h720, 1'b0, 32'h0, 4'hF, 32'h7777_1111});
    @(negedge clk); chk("t5_idle_memEn", memEnable, 0); chk("t5_idle_addr", memAddress, 0);
    tick();
    @(negedge clk); chk("t5_lastgrant_kept", memAddress, 24'h710);
    tick(); reqAEnable = 0; memDataRead = 32'h7777_1111;
    @(negedge clk); chk("t5_b_next", memAddress, 24'h720);
    tick(); reqBEnable = 0;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    // 6: stuck memory, timeout after 4 counted cycles, then B
    reqAAddress = 24'h800; memBusy = 1; reqAEnable = 1;
    tick();
    reqBAddress = 24'h900; reqBEnable = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t6_no_err", arbError, 0); chk("t6_busyA", reqABusy, 1);
      tick();
    end
    @(negedge clk); chk("t6_err", arbError, 1); chk("t6_busyA_low", reqABusy, 0);
    chk("t6_readA", reqADataRead, 32'hFFFF_FFFF);
    tick(); reqAEnable = 0; memBusy = 0; memDataRead = 32'h9999_0000;
    q.push_back('{1'b1, 24'h900, 1'b0, 32'h0, 4'hF, 32'h9999_0000});
    @(negedge clk); chk("t6_err_pulse", arbError, 0); chk("t6_b_addr", memAddress, 24'h900);
    tick(); reqBEnable = 0;
`else
    @(negedge clk); chk("no_timeout_err", arbError, 0);
`endif

    repeat (3) tick();
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
